// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: headings, PS/2 scan codes and the receive FSM states.
// The collision logic imports the same direction encoding.
package snake_pkg;

  typedef enum logic [1:0] {
    DirUp    = 2'b00,
    DirDown  = 2'b01,
    DirLeft  = 2'b10,
    DirRight = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StCheck = 2'b10
  } rx_state_e;

  // Prefix bytes
  localparam logic [7:0] ScanExt   = 8'hE0;
  localparam logic [7:0] ScanBrk   = 8'hF0;
  localparam logic [7:0] ScanEnter = 8'h5A;

  // Arrow keys (valid only after ScanExt)
  localparam logic [7:0] ScanArrowUp    = 8'h75;
  localparam logic [7:0] ScanArrowDown  = 8'h72;
  localparam logic [7:0] ScanArrowLeft  = 8'h6B;
  localparam logic [7:0] ScanArrowRight = 8'h74;

  // WASD keys (valid only without ScanExt)
  localparam logic [7:0] ScanW = 8'h1D;
  localparam logic [7:0] ScanS = 8'h1B;
  localparam logic [7:0] ScanA = 8'h1C;
  localparam logic [7:0] ScanD = 8'h23;

  // Up<->down and left<->right differ only in the low bit.
  function automatic dir_e dir_reverse(input dir_e dir);
    return dir_e'({dir[1], ~dir[0]});
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw clock/data, frames 11-bit words and
// flags parity, start, stop and inter-edge timeout errors.
module ps2_rx
  import snake_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kb_clk,
  input  logic       kb_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       err
);

  localparam int unsigned TmoWidth = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  rx_state_e              state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [TmoWidth-1:0]    tmo_q, tmo_d;
  logic                   frame_ok;

  // Sync flops reset to the PS/2 idle level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], kb_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], kb_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
    end
  end

  // shift_q holds {stop, parity, d7..d0} once ten bits have arrived.
  assign frame_ok  = shift_q[9] & (^shift_q[8:0]);
  assign data_byte = shift_q[7:0];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tmo_d      = tmo_q;
    byte_valid = 1'b0;
    err        = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (fall) begin
          if (!data_s) begin
            state_d   = StShift;
            bit_cnt_d = '0;
          end else begin
            err = 1'b1;
          end
        end
      end

      StShift: begin
        if (fall) begin
          tmo_d   = '0;
          shift_d = {data_s, shift_q[9:1]};
          if (bit_cnt_q == 4'd9) begin
            state_d   = StCheck;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_q == TmoLast) begin
          err       = 1'b1;
          tmo_d     = '0;
          bit_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StCheck: begin
        tmo_d      = '0;
        byte_valid = frame_ok;
        err        = ~frame_ok;
        state_d    = StIdle;
        // An edge in this cycle already starts the next frame.
        if (fall) begin
          if (!data_s) begin
            state_d   = StShift;
            bit_cnt_d = '0;
          end else begin
            err = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: rtl/kb_direction_decoder.sv
// Turns PS/2 keyboard scan codes into a snake heading, a start pulse and a frame error pulse.
// Reversing onto the snake's own body is filtered out here.
module kb_direction_decoder
  import snake_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       VGA_clk,
  input  logic       reset_n,
  input  logic       KB_clk,
  input  logic       data,
  output logic [1:0] direction,
  output logic       dir_valid,
  output logic       start_key,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  dir_e       dir_q, dir_d;
  logic       dir_valid_q, dir_valid_d;
  logic       start_q, start_d;
  logic       frame_err_q;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       key_hit;
  dir_e       key_dir;
  logic [8:0] key;

  ps2_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk        (VGA_clk),
    .rst_n      (reset_n),
    .kb_clk     (KB_clk),
    .kb_data    (data),
    .data_byte  (rx_byte),
    .byte_valid (rx_valid),
    .err        (rx_err)
  );

  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q       <= DirRight;
      dir_valid_q <= 1'b0;
      start_q     <= 1'b0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      dir_q       <= dir_d;
      dir_valid_q <= dir_valid_d;
      start_q     <= start_d;
      frame_err_q <= rx_err;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
    end
  end

  assign key = {ext_q, rx_byte};

  always_comb begin
    key_hit = 1'b0;
    key_dir = dir_q;
    case (key)
      {1'b1, ScanArrowUp}:    begin key_hit = 1'b1; key_dir = DirUp;    end
      {1'b1, ScanArrowDown}:  begin key_hit = 1'b1; key_dir = DirDown;  end
      {1'b1, ScanArrowLeft}:  begin key_hit = 1'b1; key_dir = DirLeft;  end
      {1'b1, ScanArrowRight}: begin key_hit = 1'b1; key_dir = DirRight; end
      {1'b0, ScanW}:          begin key_hit = 1'b1; key_dir = DirUp;    end
      {1'b0, ScanS}:          begin key_hit = 1'b1; key_dir = DirDown;  end
      {1'b0, ScanA}:          begin key_hit = 1'b1; key_dir = DirLeft;  end
      {1'b0, ScanD}:          begin key_hit = 1'b1; key_dir = DirRight; end
      default: ;
    endcase
  end

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    dir_d       = dir_q;
    dir_valid_d = 1'b0;
    start_d     = 1'b0;

    if (rx_valid) begin
      if (rx_byte == ScanExt) begin
        ext_d = 1'b1;
      end else if (rx_byte == ScanBrk) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!brk_q) begin
          if (!ext_q && rx_byte == ScanEnter) begin
            start_d = 1'b1;
          end
          if (key_hit && key_dir != dir_q && key_dir != dir_reverse(dir_q)) begin
            dir_d       = key_dir;
            dir_valid_d = 1'b1;
          end
        end
      end
    end
  end

  assign direction = dir_q;
  assign dir_valid = dir_valid_q;
  assign start_key = start_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_kb_direction_decoder.sv
// Randomized and directed bench for kb_direction_decoder against a key-table reference model.
module tb_kb_direction_decoder;

  localparam int unsigned Tmo = 200;

  logic       VGA_clk;
  logic       reset_n;
  logic       KB_clk;
  logic       data;
  logic [1:0] direction;
  logic       dir_valid;
  logic       start_key;
  logic       frame_err;

  int passed = 0;
  int total  = 0;

  int dv_cnt = 0;
  int sk_cnt = 0;
  int fe_cnt = 0;

  // Reference model state: heading 0 up, 1 down, 2 left, 3 right.
  int m_dir;
  bit m_ext;
  bit m_brk;
  int opposite [4] = '{1, 0, 3, 2};
  int exp_dv;
  int exp_sk;
  int exp_fe;

  kb_direction_decoder #(
    .TIMEOUT_CYCLES (Tmo),
    .SYNC_STAGES    (2)
  ) dut (
    .VGA_clk   (VGA_clk),
    .reset_n   (reset_n),
    .KB_clk    (KB_clk),
    .data      (data),
    .direction (direction),
    .dir_valid (dir_valid),
    .start_key (start_key),
    .frame_err (frame_err)
  );

  initial VGA_clk = 1'b0;
  always #5 VGA_clk = ~VGA_clk;

  always @(negedge VGA_clk) begin
    if (dir_valid === 1'b1) dv_cnt++;
    if (start_key === 1'b1) sk_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge VGA_clk);
  endtask

  task automatic model_reset();
    m_dir = 3;
    m_ext = 0;
    m_brk = 0;
  endtask

  // Expected effect of one good byte on the model and on the pulse outputs.
  task automatic model_byte(input logic [7:0] b);
    int h;
    h      = -1;
    exp_dv = 0;
    exp_sk = 0;
    exp_fe = 0;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_brk) begin
        if (m_ext) begin
          case (b)
            8'h75: h = 0;
            8'h72: h = 1;
            8'h6B: h = 2;
            8'h74: h = 3;
            default: ;
          endcase
        end else begin
          case (b)
            8'h1D: h = 0;
            8'h1B: h = 1;
            8'h1C: h = 2;
            8'h23: h = 3;
            8'h5A: exp_sk = 1;
            default: ;
          endcase
        end
        if (h >= 0 && h != m_dir && h != opposite[m_dir]) begin
          m_dir  = h;
          exp_dv = 1;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // Drives nbits of the 11-bit frame; always leaves KB_clk and data high.
  task automatic send_frame(input logic [7:0] b, input bit bad_parity, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      data = bits[i];
      wait_cyc(4);
      KB_clk = 1'b0;
      wait_cyc(8);
      KB_clk = 1'b1;
      wait_cyc(4);
    end
    data = 1'b1;
    wait_cyc(6);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
    model_byte(b);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(2);
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_cyc(3);
    total++;
    if (direction !== 2'b11) $display("FAIL reset_direction got %b want 11", direction);
    else passed++;
    total++;
    if ({dir_valid, start_key, frame_err} !== 3'b000)
      $display("FAIL reset_pulses got %b want 000", {dir_valid, start_key, frame_err});
    else passed++;
    reset_n = 1'b1;
    wait_cyc(2);
    model_reset();
  endtask

  task automatic test_arrow();
    int dv0;
    do_reset();
    dv0 = dv_cnt;
    send_byte(8'hE0);
    send_byte(8'h75);
    total++;
    if (direction !== 2'b00) $display("FAIL arrow_up_dir got %b want 00", direction);
    else passed++;
    total++;
    if (dv_cnt - dv0 !== 1) $display("FAIL arrow_up_pulses got %0d want 1", dv_cnt - dv0);
    else passed++;
  endtask

  task automatic test_wasd();
    int dv0;
    do_reset();
    dv0 = dv_cnt;
    send_byte(8'h1C);
    total++;
    if (direction !== 2'b11 || dv_cnt != dv0)
      $display("FAIL wasd_reverse got dir %b pulses %0d want 11 0", direction, dv_cnt - dv0);
    else passed++;
    send_byte(8'h1D);
    total++;
    if (direction !== 2'b00 || dv_cnt - dv0 != 1)
      $display("FAIL wasd_up got dir %b pulses %0d want 00 1", direction, dv_cnt - dv0);
    else passed++;
  endtask

  task automatic test_break();
    int dv0;
    dv0 = dv_cnt;
    send_byte(8'hF0);
    send_byte(8'h1D);
    send_byte(8'hF0);
    send_byte(8'h1C);
    total++;
    if (direction !== 2'b00 || dv_cnt != dv0)
      $display("FAIL break_ignored got dir %b pulses %0d want 00 0", direction, dv_cnt - dv0);
    else passed++;
    send_byte(8'h1C);
    total++;
    if (direction !== 2'b10 || dv_cnt - dv0 != 1)
      $display("FAIL break_cleared got dir %b pulses %0d want 10 1", direction, dv_cnt - dv0);
    else passed++;
  endtask

  task automatic test_start_parity();
    int fe0;
    int sk0;
    fe0 = fe_cnt;
    sk0 = sk_cnt;
    send_frame(8'h5A, 1'b1, 11);
    total++;
    if (fe_cnt - fe0 != 1 || sk_cnt != sk0)
      $display("FAIL bad_parity got err %0d start %0d want 1 0", fe_cnt - fe0, sk_cnt - sk0);
    else passed++;
    send_byte(8'h5A);
    total++;
    if (sk_cnt - sk0 != 1 || fe_cnt - fe0 != 1)
      $display("FAIL start_key got start %0d err %0d want 1 1", sk_cnt - sk0, fe_cnt - fe0);
    else passed++;
  endtask

  task automatic test_timeout();
    int fe0;
    int dv0;
    do_reset();
    fe0 = fe_cnt;
    send_frame(8'h1B, 1'b0, 5);
    wait_cyc(Tmo + 30);
    total++;
    if (fe_cnt - fe0 != 1) $display("FAIL timeout_err got %0d want 1", fe_cnt - fe0);
    else passed++;
    dv0 = dv_cnt;
    send_byte(8'h1B);
    total++;
    if (direction !== 2'b01 || dv_cnt - dv0 != 1 || fe_cnt - fe0 != 1)
      $display("FAIL timeout_recover got dir %b pulses %0d err %0d want 01 1 1",
               direction, dv_cnt - dv0, fe_cnt - fe0);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    int dv0;
    int sk0;
    int fe0;
    do_reset();
    send_byte(8'hE0);
    dv0 = dv_cnt;
    sk0 = sk_cnt;
    fe0 = fe_cnt;
    send_frame(8'h74, 1'b0, 5);
    do_reset();
    wait_cyc(Tmo + 30);
    total++;
    if (direction !== 2'b11) $display("FAIL midreset_dir got %b want 11", direction);
    else passed++;
    total++;
    if (dv_cnt != dv0 || sk_cnt != sk0 || fe_cnt != fe0)
      $display("FAIL midreset_pulses got %0d %0d %0d want 0 0 0",
               dv_cnt - dv0, sk_cnt - sk0, fe_cnt - fe0);
    else passed++;
    // The E0 prefix must not survive reset.
    send_byte(8'h75);
    total++;
    if (direction !== 2'b11 || dv_cnt != dv0)
      $display("FAIL midreset_ext got dir %b pulses %0d want 11 0", direction, dv_cnt - dv0);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D,
                              8'h1B, 8'h1C, 8'h23, 8'h5A, 8'hFA, 8'hAA, 8'hE0};
    logic [7:0] b;
    bit         bad;
    int         dv0;
    int         sk0;
    int         fe0;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(7) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(13)];
      bad = ($urandom_range(9) == 0);
      dv0 = dv_cnt;
      sk0 = sk_cnt;
      fe0 = fe_cnt;
      send_frame(b, bad, 11);
      if (bad) begin
        exp_dv = 0;
        exp_sk = 0;
        exp_fe = 1;
      end else begin
        model_byte(b);
      end
      total++;
      if (direction !== 2'(m_dir) || dv_cnt - dv0 != exp_dv || sk_cnt - sk0 != exp_sk ||
          fe_cnt - fe0 != exp_fe)
        $display("FAIL random_%0d byte %h bad %0d got dir %b dv %0d sk %0d fe %0d want %0d %0d %0d %0d",
                 n, b, bad, direction, dv_cnt - dv0, sk_cnt - sk0, fe_cnt - fe0,
                 m_dir, exp_dv, exp_sk, exp_fe);
      else passed++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    KB_clk  = 1'b1;
    data    = 1'b1;
    model_reset();
    test_reset();
    test_arrow();
    test_wasd();
    test_break();
    test_start_parity();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
